// File: rtl/data_ram_arb.sv
// Data RAM arbiter: CPU MA-stage byte/half/word access with priority over a debug host (HOST_STARVE_LIMIT_EN enables the host starvation limit).
// Latency: host grant and CPU write are combinational; load data and host read data return one cycle after the address.
// Backpressure: the host holds its request until host_gnt; cpu_stall forces a CPU hold only when the starvation limit fires.
module data_ram_arb #(
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_re,
    input  logic        cpu_we,
    input  logic [11:0] cpu_adr,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_uns,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_misal,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [9:0]  host_adr,
    input  logic [31:0] host_wdata,
    output logic        host_gnt,
    output logic        host_rvld,
    output logic [31:0] host_rdata,
    output logic [9:0]  ram_radr,
    input  logic [31:0] ram_rdata,
    output logic [9:0]  ram_wadr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_wen
);

    if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_starve_range
        $error("STARVE_MAX must be within 1..255");
    end

    logic        cpu_act;
    logic [1:0]  lane;
    logic        misal;
    logic        force_gnt;
    logic        cpu_go;
    logic        host_wr;
    logic        host_rd;
    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic [31:0] ld_ext;

    logic        host_rd_q;
    logic        ld_q;
    logic [1:0]  ld_lane_q;
    logic [1:0]  ld_size_q;
    logic        ld_uns_q;
    logic [31:0] rdata_q;

    assign cpu_act   = cpu_re | cpu_we;
    assign lane      = cpu_adr[1:0];
    assign misal     = ((cpu_size == 2'b01) & lane[0]) | (cpu_size[1] & (lane != 2'b00));
    assign cpu_misal = cpu_act & misal;

`ifdef HOST_STARVE_LIMIT_EN
    logic [7:0] starve_cnt;

    assign force_gnt = ~rst & host_req & (starve_cnt == 8'(STARVE_MAX));
    assign cpu_stall = force_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 8'd0;
        end else if (host_gnt) begin
            starve_cnt <= 8'd0;
        end else if (host_req) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end
`else
    assign force_gnt = 1'b0;
    assign cpu_stall = 1'b0;
`endif

    assign host_gnt = ~rst & host_req & (~cpu_act | force_gnt);
    assign host_wr  = host_gnt & host_we;
    assign host_rd  = host_gnt & ~host_we;
    // Misaligned CPU accesses never touch the RAM.
    assign cpu_go   = ~rst & cpu_act & ~force_gnt & ~misal;

    always_comb begin
        st_mask = 4'b1111;
        st_data = cpu_wdata;
        case (cpu_size)
            2'b00: begin
                st_mask = 4'b0001 << lane;
                st_data = {4{cpu_wdata[7:0]}};
            end
            2'b01: begin
                st_mask = 4'b0011 << lane;
                st_data = {2{cpu_wdata[15:0]}};
            end
            default: begin
                st_mask = 4'b1111;
                st_data = cpu_wdata;
            end
        endcase
    end

    always_comb begin
        ram_wen   = 4'b0000;
        ram_wadr  = cpu_adr[11:2];
        ram_wdata = st_data;
        if (host_wr) begin
            ram_wen   = 4'b1111;
            ram_wadr  = host_adr;
            ram_wdata = host_wdata;
        end else if (cpu_go & cpu_we) begin
            ram_wen   = st_mask;
        end
    end

    assign ram_radr = host_rd ? host_adr : cpu_adr[11:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            host_rd_q <= 1'b0;
            ld_q      <= 1'b0;
            ld_lane_q <= 2'b00;
            ld_size_q <= 2'b00;
            ld_uns_q  <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            host_rd_q <= host_rd;
            ld_q      <= cpu_go & cpu_re;
            if (cpu_go & cpu_re) begin
                ld_lane_q <= lane;
                ld_size_q <= cpu_size;
                ld_uns_q  <= cpu_uns;
            end
            rdata_q   <= cpu_rdata;
        end
    end

    always_comb begin
        logic [7:0]  sel_b;
        logic [15:0] sel_h;
        sel_h = ld_lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (ld_lane_q)
            2'd0:    sel_b = ram_rdata[7:0];
            2'd1:    sel_b = ram_rdata[15:8];
            2'd2:    sel_b = ram_rdata[23:16];
            default: sel_b = ram_rdata[31:24];
        endcase
        case (ld_size_q)
            2'b00:   ld_ext = {{24{~ld_uns_q & sel_b[7]}}, sel_b};
            2'b01:   ld_ext = {{16{~ld_uns_q & sel_h[15]}}, sel_h};
            default: ld_ext = ram_rdata;
        endcase
    end

    // Load data is taken straight off the RAM in the return cycle, otherwise the last value is held.
    assign cpu_rdata  = rst ? 32'd0 : (ld_q ? ld_ext : rdata_q);
    assign host_rvld  = host_rd_q & ~rst;
    assign host_rdata = host_rvld ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_data_ram_arb.sv
// Randomized plus directed bench for data_ram_arb against a byte-level memory reference model.
module tb_data_ram_arb;

`ifdef HOST_STARVE_LIMIT_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif
    localparam int SMAX = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_re, cpu_we, cpu_uns;
    logic [11:0] cpu_adr;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        cpu_stall, cpu_misal;
    logic        host_req, host_we, host_gnt, host_rvld;
    logic [9:0]  host_adr;
    logic [31:0] host_wdata, host_rdata;
    logic [9:0]  ram_radr, ram_wadr;
    logic [31:0] ram_rdata, ram_wdata;
    logic [3:0]  ram_wen;

    always #5 clk = ~clk;

    data_ram_arb #(.STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_size(cpu_size),
        .cpu_uns(cpu_uns), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .cpu_misal(cpu_misal),
        .host_req(host_req), .host_we(host_we), .host_adr(host_adr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvld(host_rvld),
        .host_rdata(host_rdata),
        .ram_radr(ram_radr), .ram_rdata(ram_rdata), .ram_wadr(ram_wadr),
        .ram_wdata(ram_wdata), .ram_wen(ram_wen)
    );

    // 1r1w RAM with one-cycle read latency (read returns pre-write contents).
    logic [31:0] mem [1024];
    always @(posedge clk) begin
        ram_rdata <= mem[ram_radr];
        for (int k = 0; k < 4; k++)
            if (ram_wen[k]) mem[ram_wadr][8*k +: 8] <= ram_wdata[8*k +: 8];
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    logic [31:0] ref_mem [1024];
    int          wait_cnt = 0;
    bit          exp_rvld_nxt = 0;
    logic [31:0] exp_hrd_nxt = '0;
    bit          ld_nxt = 0;
    logic [31:0] ld_val_nxt = '0;
    logic [31:0] cpu_hold = '0;
    bit          hold_known = 0;
    bit          gnt_exp = 0;

    function automatic logic [31:0] load_value(input logic [31:0] w, input int ln, input int nb, input bit uns);
        logic [31:0] v;
        v = w >> (8 * ln);
        if (nb == 1) begin
            v = v & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (nb == 2) begin
            v = v & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        bit          act, mis, force_g, gnt, cpu_do;
        int          ln, nb;
        logic [3:0]  wen;
        logic [31:0] wd, m;
        logic [9:0]  wa;
        @(negedge clk);
        if (rst) begin
            chk("rst_rvld", host_rvld, 0);
            chk("rst_hrdata", host_rdata, 0);
            chk("rst_cpu_rdata", cpu_rdata, 0);
        end else begin
            chk("host_rvld", host_rvld, exp_rvld_nxt);
            if (exp_rvld_nxt) chk("host_rdata", host_rdata, exp_hrd_nxt);
            if (ld_nxt) begin
                chk("cpu_rdata", cpu_rdata, ld_val_nxt);
                cpu_hold   = ld_val_nxt;
                hold_known = 1;
            end else if (hold_known) begin
                chk("cpu_rdata_hold", cpu_rdata, cpu_hold);
            end
        end

        act     = cpu_re || cpu_we;
        ln      = int'(cpu_adr[1:0]);
        nb      = (cpu_size == 2'd0) ? 1 : (cpu_size == 2'd1) ? 2 : 4;
        mis     = act && (ln % nb != 0);
        force_g = STARVE_ON && !rst && host_req && (wait_cnt == SMAX);
        gnt     = !rst && host_req && (!act || force_g);
        cpu_do  = !rst && act && !force_g;

        chk("host_gnt", host_gnt, gnt);
        chk("cpu_stall", cpu_stall, force_g);
        chk("cpu_misal", cpu_misal, mis);

        wen = 4'd0; wd = '0; wa = '0;
        if (gnt && host_we) begin
            wen = 4'hF; wd = host_wdata; wa = host_adr;
        end else if (cpu_do && cpu_we && !mis) begin
            wa = cpu_adr[11:2];
            for (int k = 0; k < 4; k++)
                if (k >= ln && k < ln + nb) begin
                    wen[k] = 1'b1;
                    wd[8*k +: 8] = 8'((cpu_wdata >> (8 * (k - ln))) & 32'hFF);
                end
        end
        chk("ram_wen", ram_wen, wen);
        if (wen != 0) begin
            m = '0;
            for (int k = 0; k < 4; k++) if (wen[k]) m[8*k +: 8] = 8'hFF;
            chk("ram_wadr", ram_wadr, wa);
            chk("ram_wdata", ram_wdata & m, wd);
        end
        if (!rst) chk("ram_radr", ram_radr, (gnt && !host_we) ? host_adr : cpu_adr[11:2]);

        exp_rvld_nxt = gnt && !host_we;
        exp_hrd_nxt  = ref_mem[host_adr];
        ld_nxt       = cpu_do && cpu_re && !mis;
        if (ld_nxt) ld_val_nxt = load_value(ref_mem[cpu_adr[11:2]], ln, nb, cpu_uns);
        if (cpu_do && cpu_re && mis) hold_known = 0;
        for (int k = 0; k < 4; k++)
            if (wen[k]) ref_mem[wa][8*k +: 8] = wd[8*k +: 8];

        if (rst)           wait_cnt = 0;
        else if (gnt)      wait_cnt = 0;
        else if (host_req) wait_cnt++;
        if (rst) begin
            exp_rvld_nxt = 0;
            ld_nxt       = 0;
            cpu_hold     = '0;
            hold_known   = 1;
        end
        gnt_exp = gnt;
    endtask

    task automatic cpu_idle();
        cpu_re = 0; cpu_we = 0; cpu_adr = '0; cpu_size = 2'd0; cpu_uns = 0; cpu_wdata = '0;
    endtask

    initial begin
        bit h_pend;
        int r;
        cpu_idle();
        host_req = 1; host_we = 0; host_adr = 10'd2; host_wdata = '0;
        rst = 1;
        cycle();
        chk("reset_gnt", host_gnt, 0);
        chk("reset_wen", ram_wen, 0);
        chk("reset_cpu_rdata", cpu_rdata, 0);
        tick();
        rst = 0; host_req = 0;

        for (int i = 0; i < 16; i++) begin
            host_req = 1; host_we = 1; host_adr = 10'(i); host_wdata = $urandom;
            cycle(); tick();
        end
        host_req = 0;

        cpu_we = 1; cpu_adr = 12'h005; cpu_size = 2'd0; cpu_wdata = 32'hAB;
        cycle();
        chk("sb_wen", ram_wen, 4'b0010);
        chk("sb_wadr", ram_wadr, 10'd1);
        chk("sb_wdata", ram_wdata, 32'hABABABAB);
        tick();
        cpu_idle();
        host_req = 1; host_we = 1; host_adr = 10'd1; host_wdata = 32'h80FF7F01;
        cycle(); tick();
        host_adr = 10'd3; host_wdata = 32'h12345678;
        cycle(); tick();
        host_req = 0;

        cpu_re = 1; cpu_adr = 12'h006; cpu_size = 2'd0; cpu_uns = 0;
        cycle(); tick();
        cpu_size = 2'd1; cpu_uns = 1;
        cycle();
        chk("lb_sext", cpu_rdata, 32'hFFFFFFFF);
        tick();
        cpu_idle();
        cycle();
        chk("lhu_zext", cpu_rdata, 32'h000080FF);
        tick();
        cycle();
        chk("rdata_hold", cpu_rdata, 32'h000080FF);
        tick();

        cpu_re = 1; cpu_adr = 12'h002; cpu_size = 2'd2;
        cycle();
        chk("lw_misal", cpu_misal, 1);
        chk("lw_misal_wen", ram_wen, 0);
        tick();
        cpu_re = 0; cpu_we = 1; cpu_adr = 12'h001; cpu_size = 2'd1; cpu_wdata = 32'h5A5A;
        cycle();
        chk("sh_misal", cpu_misal, 1);
        chk("sh_misal_wen", ram_wen, 0);
        tick();
        cpu_idle();

        host_req = 1; host_we = 0; host_adr = 10'd3;
        cycle();
        chk("hrd_gnt", host_gnt, 1);
        tick();
        host_req = 0;
        cycle();
        chk("hrd_rvld", host_rvld, 1);
        chk("hrd_data", host_rdata, 32'h12345678);
        tick();

        host_req = 1; host_we = 0; host_adr = 10'd7;
        for (int i = 0; i < 20; i++) begin
            cpu_re = 1; cpu_size = 2'd2; cpu_adr = {6'd0, 4'($urandom), 2'b00};
            cycle();
            chk("starve_gnt", host_gnt, STARVE_ON && (i == SMAX || i == 2*SMAX + 1));
            chk("starve_stall", cpu_stall, STARVE_ON && (i == SMAX || i == 2*SMAX + 1));
            tick();
        end
        cpu_idle();
        cycle();
        chk("idle_gnt", host_gnt, 1);
        tick();

        host_req = 1; host_we = 0; host_adr = 10'd3;
        cycle(); tick();
        rst = 1;
        cycle();
        chk("rst_after_rd_rvld", host_rvld, 0);
        chk("rst_after_rd_hrdata", host_rdata, 0);
        chk("rst_after_rd_gnt", host_gnt, 0);
        chk("rst_after_rd_wen", ram_wen, 0);
        chk("rst_after_rd_stall", cpu_stall, 0);
        tick();
        rst = 0; host_req = 0;

        h_pend = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!h_pend && $urandom_range(0, 2) == 0) begin
                h_pend = 1;
                host_we = 1'($urandom); host_adr = 10'($urandom_range(0, 15)); host_wdata = $urandom;
            end
            host_req = h_pend;
            r = $urandom_range(0, 9);
            cpu_re = (r >= 3 && r < 6); cpu_we = (r >= 6);
            cpu_adr = {6'd0, 6'($urandom)}; cpu_size = 2'($urandom);
            cpu_uns = 1'($urandom); cpu_wdata = $urandom;
            rst = ($urandom_range(0, 199) == 0);
            cycle();
            if (gnt_exp) h_pend = 0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
